// File: rtl/npc_multicycle_core.sv
// npc_multicycle_core: multi-cycle RV32I/RV32E core for an ADD/ADDI/SUB/LUI/AUIPC/JAL/JALR/EBREAK subset.
// Define NPC_COMMIT_TRACE_EN to add the commit trace outputs.
module npc_multicycle_core #(
  parameter int          NR_REGS  = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        halt,
  output logic [1:0]  halt_code,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
`ifdef NPC_COMMIT_TRACE_EN
  ,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_wdata
`endif
);
  localparam int AW = NR_REGS == 16 ? 4 : 5;
  localparam logic [5:0] NR = 6'(NR_REGS);
  if (NR_REGS != 16 && NR_REGS != 32) begin : g_bad_nr_regs
    $error("NR_REGS must be 16 or 32");
  end
  typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, ir, wdata, npc;
  logic [4:0] rd_q;
  logic [31:0] regs [NR_REGS];
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [31:0] rv1, rv2, imm_i, imm_u, imm_j, result, target;
  logic is_add, is_sub, is_addi, is_lui, is_auipc, is_jal, is_jalr, is_ebreak;
  logic bad_reg, legal, misaligned, stop;
  logic [1:0] code;
  assign {f7, rs2, rs1, f3, rd, op} = ir;
  assign rv1 = regs[rs1[AW-1:0]];
  assign rv2 = regs[rs2[AW-1:0]];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  always_comb begin
    is_add     = op == 7'b0110011 && f3 == 3'd0 && f7 == 7'b0000000;
    is_sub     = op == 7'b0110011 && f3 == 3'd0 && f7 == 7'b0100000;
    is_addi    = op == 7'b0010011 && f3 == 3'd0;
    is_lui     = op == 7'b0110111;
    is_auipc   = op == 7'b0010111;
    is_jal     = op == 7'b1101111;
    is_jalr    = op == 7'b1100111 && f3 == 3'd0;
    is_ebreak  = ir == 32'h0010_0073;
    bad_reg    = ((is_add || is_sub || is_addi || is_jalr) && {1'b0, rs1} >= NR) ||
                 ((is_add || is_sub) && {1'b0, rs2} >= NR) || {1'b0, rd} >= NR;
    legal      = (is_add || is_sub || is_addi || is_lui || is_auipc || is_jal || is_jalr) && !bad_reg;
    result     = is_add ? rv1 + rv2 : is_sub ? rv1 - rv2 : is_addi ? rv1 + imm_i :
                 is_lui ? imm_u : is_auipc ? pc + imm_u : pc + 32'd4;
    target     = is_jal ? pc + imm_j : is_jalr ? (rv1 + imm_i) & ~32'd1 : pc + 32'd4;
    misaligned = (is_jal || is_jalr) && target[1];
    stop       = !legal || misaligned;
    code       = is_ebreak ? 2'd0 : !legal ? 2'd1 : 2'd2;
    state_n    = state == FETCH ? (imem_valid ? EXEC : FETCH) :
                 state == EXEC  ? (stop ? HALT : WB) :
                 state == WB    ? FETCH : HALT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      wdata     <= '0;
      npc       <= '0;
      rd_q      <= '0;
      halt_code <= '0;
      regs      <= '{default: '0};
    end else begin
      state <= state_n;
      if (state == FETCH && imem_valid) ir <= imem_rdata;
      if (state == EXEC) begin
        wdata <= result;
        npc   <= target;
        rd_q  <= rd;
        if (stop) halt_code <= code;
      end
      if (state == WB) begin
        pc <= npc;
        if (rd_q != '0) regs[rd_q[AW-1:0]] <= wdata;
      end
    end
  end
  assign imem_req  = state == FETCH;
  assign imem_addr = pc;
  assign halt      = state == HALT;
  assign dbg_rdata = {1'b0, dbg_raddr} < NR ? regs[dbg_raddr[AW-1:0]] : '0;
`ifdef NPC_COMMIT_TRACE_EN
  assign commit_valid = state == WB;
  assign commit_pc    = pc;
  assign commit_inst  = ir;
  assign commit_rd    = rd_q;
  assign commit_wdata = wdata;
`endif
endmodule
